// File: rtl/sdft_pkg.sv
// Shared definitions for the sliding-DFT sequencer.
// Holds the sequencer FSM state encoding and the default geometry constants
// (bins per line, samples per line readout, bin read latency).
package sdft_pkg;

  localparam int LIMIT_BINS_DEF = 32;
  localparam int LINE_DECIM_DEF = 8;
  localparam int READ_LAT_DEF   = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    GUARD,
    CALC,
    RD_ISSUE,
    RD_STREAM,
    RD_DRAIN,
    RD_GUARD
  } sdft_state_e;

endpackage

// File: rtl/sdft_read_pipe.sv
// Read-latency delay line for the sequencer's bin readout.
// Tags every streamed bin address with a valid bit and carries both for
// READ_LAT cycles so they line up with the sdft core's registered bin output.
//   clk, reset  : clock, synchronous active-high reset (clears all stages)
//   tag_vld_i   : address presented this cycle belongs to the line stream
//   tag_idx_i   : bin index presented this cycle
//   vld_o/idx_o : tag delayed by READ_LAT cycles
module sdft_read_pipe #(
  parameter int READ_LAT   = 2,
  parameter int BIN_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tag_vld_i,
  input  logic [BIN_ADDR_W-1:0] tag_idx_i,
  output logic                  vld_o,
  output logic [BIN_ADDR_W-1:0] idx_o
);

  logic [READ_LAT-1:0]                 vld_q;
  logic [READ_LAT-1:0][BIN_ADDR_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q[0] <= tag_vld_i;
      idx_q[0] <= tag_idx_i;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[READ_LAT-1];
  assign idx_o = idx_q[READ_LAT-1];

endmodule

// File: rtl/sdft_sequencer.sv
// Sliding-DFT sequencer.
// Feeds ADC samples one at a time into an external sdft core (start/ready
// handshake), and after every LINE_DECIM processed samples streams all
// LIMIT_BINS bin magnitudes out as one spectral line.
//   clk, reset                 : single clock, synchronous active-high reset
//   adc_valid/adc_sample       : one-cycle sample strobe and data
//   sdft_sample/sdft_start     : sample and one-cycle start to the core
//   sdft_read/sdft_bin_addr    : bin read strobe and address to the core
//   sdft_ready/sdft_bin_out    : core idle flag and bin magnitude (READ_LAT late)
//   line_valid/index/mag/done  : streamed spectral line, done on last bin
//   overflow                   : sticky flag, a sample was dropped
module sdft_sequencer
  import sdft_pkg::*;
#(
  parameter int  DATA_W     = 8,
  parameter int  FREQ_W     = 16,
  parameter int  LIMIT_BINS = LIMIT_BINS_DEF,
  parameter int  LINE_DECIM = LINE_DECIM_DEF,
  parameter int  READ_LAT   = READ_LAT_DEF,
  localparam int BIN_ADDR_W = $clog2(LIMIT_BINS),
  localparam int DEC_W      = $clog2(LINE_DECIM + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adc_valid,
  input  logic [DATA_W-1:0]     adc_sample,
  output logic [DATA_W-1:0]     sdft_sample,
  output logic                  sdft_start,
  output logic                  sdft_read,
  output logic [BIN_ADDR_W-1:0] sdft_bin_addr,
  input  logic                  sdft_ready,
  input  logic [FREQ_W-1:0]     sdft_bin_out,
  output logic                  line_valid,
  output logic [BIN_ADDR_W-1:0] line_index,
  output logic [FREQ_W-1:0]     line_mag,
  output logic                  line_done,
  output logic                  overflow
);

  localparam int DRN_W = $clog2(READ_LAT + 1);
  localparam logic [BIN_ADDR_W-1:0] LAST_ADDR = BIN_ADDR_W'(LIMIT_BINS - 1);
  localparam logic [DEC_W-1:0]      DEC_LAST  = DEC_W'(LINE_DECIM - 1);
  localparam logic [DRN_W-1:0]      DRN_LAST  = DRN_W'(READ_LAT - 1);

  sdft_state_e state_q, state_d;

  logic                  pend_q;
  logic [DATA_W-1:0]     pend_smp_q;
  logic [DATA_W-1:0]     smp_q;
  logic                  ovf_q;
  logic                  line_req_q;
  logic [DEC_W-1:0]      dec_q;
  logic [BIN_ADDR_W-1:0] addr_q;
  logic [DRN_W-1:0]      drn_q;
  logic                  start_c, read_c;
  logic                  pipe_vld;
  logic [BIN_ADDR_W-1:0] pipe_idx;

  // A strobe arriving in IDLE can launch straight away; it lands in the
  // pending register and START consumes it on the following cycle.
  logic smp_avail;
  assign smp_avail = pend_q | adc_valid;

  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    read_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (smp_avail && sdft_ready)       state_d = START;
        else if (line_req_q && sdft_ready) state_d = RD_ISSUE;
      end
      START: begin
        start_c = 1'b1;
        state_d = GUARD;
      end
      // Core may not drop ready until a cycle after start; skip one cycle.
      GUARD: state_d = CALC;
      CALC: if (sdft_ready) state_d = IDLE;
      RD_ISSUE: begin
        read_c  = 1'b1;
        state_d = RD_STREAM;
      end
      RD_STREAM: begin
        read_c = 1'b1;
        if (addr_q == LAST_ADDR) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        read_c = 1'b1;
        if (drn_q == DRN_LAST) state_d = RD_GUARD;
      end
      RD_GUARD: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pend_smp_q <= '0;
      smp_q      <= '0;
      ovf_q      <= 1'b0;
      line_req_q <= 1'b0;
      dec_q      <= '0;
      addr_q     <= '0;
      drn_q      <= '0;
    end else begin
      state_q <= state_d;

      // START frees the pending slot this cycle, so a strobe coinciding
      // with it reloads the slot instead of counting as a drop.
      if (adc_valid) begin
        if (pend_q && state_q != START) begin
          ovf_q <= 1'b1;
        end else begin
          pend_q     <= 1'b1;
          pend_smp_q <= adc_sample;
        end
      end else if (state_q == START) begin
        pend_q <= 1'b0;
      end

      if (state_q == IDLE && state_d == START)
        smp_q <= pend_q ? pend_smp_q : adc_sample;

      // Only completed calculations count, so dropped samples never do.
      if (state_q == CALC && sdft_ready) begin
        if (dec_q == DEC_LAST) begin
          dec_q      <= '0;
          line_req_q <= 1'b1;
        end else begin
          dec_q <= dec_q + 1'b1;
        end
      end

      case (state_q)
        RD_ISSUE: begin
          line_req_q <= 1'b0;
          addr_q     <= '0;
        end
        RD_STREAM: if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
        RD_DRAIN: begin
          if (drn_q == DRN_LAST) begin
            drn_q  <= '0;
            addr_q <= '0;
          end else begin
            drn_q <= drn_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sdft_read_pipe #(
    .READ_LAT  (READ_LAT),
    .BIN_ADDR_W(BIN_ADDR_W)
  ) u_read_pipe (
    .clk      (clk),
    .reset    (reset),
    .tag_vld_i(state_q == RD_STREAM),
    .tag_idx_i(addr_q),
    .vld_o    (pipe_vld),
    .idx_o    (pipe_idx)
  );

  assign sdft_sample   = smp_q;
  assign sdft_start    = start_c;
  assign sdft_read     = read_c;
  assign sdft_bin_addr = addr_q;
  assign overflow      = ovf_q;

  // Gate the core's bus so the line outputs read zero between lines.
  assign line_valid = pipe_vld;
  assign line_index = pipe_vld ? pipe_idx : '0;
  assign line_mag   = pipe_vld ? sdft_bin_out : '0;
  assign line_done  = pipe_vld && (pipe_idx == LAST_ADDR);

endmodule

// File: doc/sdft_sequencer.md
SDFT_SEQUENCER -- requirements
Module: sdft_sequencer

Interface
REQ-001 SHALL have parameters: DATA_W=8 (sample width); FREQ_W=16 (magnitude width); LIMIT_BINS=32 (bins per line); LINE_DECIM=8 (samples per line readout, >=1); READ_LAT=2 (cycles from bin_addr presented during sdft READ to bin_out valid).
REQ-002 SHALL derive BIN_ADDR_W = clog2(LIMIT_BINS) and DEC_W = clog2(LINE_DECIM+1).
REQ-003 SHALL have ports, in this order: clk in 1 (single clock); reset in 1 (synchronous, active-high).
REQ-004 SHALL have: adc_valid in 1 (one-cycle sample strobe); adc_sample in DATA_W (sample, valid with adc_valid).
REQ-005 SHALL have: sdft_sample out DATA_W; sdft_start out 1; sdft_read out 1; sdft_bin_addr out BIN_ADDR_W; sdft_ready in 1; sdft_bin_out in FREQ_W.
REQ-006 SHALL have: line_valid out 1; line_index out BIN_ADDR_W; line_mag out FREQ_W; line_done out 1 (pulse with last bin); overflow out 1 (sticky dropped-sample flag).

Function
REQ-007 SHALL use FSM states IDLE, START, GUARD, CALC, RD_ISSUE, RD_STREAM, RD_DRAIN, RD_GUARD.
REQ-008 SHALL hold a 1-deep pending-sample register; adc_valid loads it and sets pend; adc_valid while pend already set SHALL drop the new sample and set overflow.
REQ-009 IDLE: if pend and sdft_ready -> START; else if line_req and sdft_ready -> RD_ISSUE; pending sample has priority over readout.
REQ-010 START (1 cycle): sdft_start=1, sdft_sample=pending value, clear pend (a same-cycle adc_valid SHALL reload pend, not overflow); -> GUARD.
REQ-011 sdft_sample SHALL stay constant from START until the next START.
REQ-012 GUARD (1 cycle, sdft_ready ignored) -> CALC; CALC waits for sdft_ready=1 -> IDLE, incrementing the decimation counter.
REQ-013 Decimation counter reaching LINE_DECIM SHALL clear to 0 and set line_req.
REQ-014 RD_ISSUE (1 cycle): sdft_read=1, sdft_bin_addr=0, clear line_req -> RD_STREAM.
REQ-015 RD_STREAM: sdft_read=1, sdft_bin_addr steps 0..LIMIT_BINS-1, one per cycle; after LIMIT_BINS-1 -> RD_DRAIN.
REQ-016 RD_DRAIN: sdft_read=1, sdft_bin_addr held at LIMIT_BINS-1 for READ_LAT cycles -> RD_GUARD.
REQ-017 RD_GUARD (1 cycle): sdft_read=0 -> IDLE.
REQ-018 sdft_start and sdft_read SHALL never be high in the same cycle.
REQ-019 A READ_LAT-deep valid/index delay line SHALL tag each RD_STREAM address; line_valid=1 and line_mag=sdft_bin_out exactly READ_LAT cycles after address k is presented in RD_STREAM, line_index=k.
REQ-020 line_valid SHALL be high exactly LIMIT_BINS consecutive cycles per line, indices 0..LIMIT_BINS-1 ascending; line_done=1 with index LIMIT_BINS-1 only.
REQ-021 adc_valid during any readout state SHALL be captured per REQ-008 and served on return to IDLE.
REQ-022 Samples SHALL NOT be counted toward decimation if dropped.
REQ-023 overflow SHALL clear only on reset.

Reset
REQ-024 reset SHALL force IDLE and clear pend, line_req, decimation counter, delay line and overflow.
REQ-025 Reset values: sdft_start=0, sdft_read=0, sdft_bin_addr=0, sdft_sample=0, line_valid=0, line_index=0, line_mag=0, line_done=0, overflow=0.
REQ-026 reset mid-readout SHALL abort with no further line_valid; reset mid-CALC SHALL wait in IDLE for sdft_ready before any new start.

Structure
REQ-027 FSM state encodings and the default LIMIT_BINS/LINE_DECIM/READ_LAT constants SHALL live in shared package sdft_pkg.
REQ-028 The read-latency delay line SHALL be sub-module sdft_read_pipe (parameters READ_LAT, BIN_ADDR_W); everything else is in sdft_sequencer.

Verification
REQ-029 Single sample 0x7F with sdft idle -> sdft_start high 1 cycle at cycle t+1, sdft_sample=0x7F, next start only after sdft_ready returns.
REQ-030 8 samples with LINE_DECIM=8 -> one readout: 32 line_valid cycles, indices 0..31, line_mag equals model |bin| per index, line_done on index 31.
REQ-031 adc_valid at cycles 5 of readout and again at 10 of readout -> first sample started after RD_GUARD, second dropped, overflow=1 and stays 1.
REQ-032 adc_valid in the same cycle as START -> pend reloaded, overflow stays 0, second start follows the first calc.
REQ-033 reset asserted at readout index 12 -> line_valid low next cycle, all outputs at reset values, no line_done.
REQ-034 Sample strobe every cycle for 1000 cycles -> sdft_start/sdft_read never coincide, sdft_sample stable between starts, overflow=1.
